// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter load table and pulse register offsets.
package apu_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_SWEEP = 2'd1;
    localparam logic [1:0] REG_TLO   = 2'd2;
    localparam logic [1:0] REG_THI   = 2'd3;

    // Indexed by wdata[7:3] of a timer-high write.
    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/length_counter.sv
// Channel length counter: table load, half-frame decrement with halt, enable gating.
module length_counter
    import apu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] load_idx,
    input  logic       halt,
    input  logic       hframe_tick,
    input  logic       ch_enable,
    output logic       active
);

    logic [7:0] len;

    // Priority: reset, disable, load, decrement. A load beats a same-cycle tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len <= 8'd0;
        end else if (!ch_enable) begin
            len <= 8'd0;
        end else if (load) begin
            len <= LEN_TABLE[load_idx];
        end else if (hframe_tick && !halt && (len != 8'd0)) begin
            len <= len - 8'd1;
        end
    end

    assign active = (len != 8'd0);

endmodule

// File: rtl/pulse_reg_writer.sv
// Pulse channel register writer: decodes CPU writes to offsets 0-3 into envelope,
// sweep, timer and duty controls, and owns the channel length counter.
module pulse_reg_writer
    import apu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        ch_enable,
    input  logic        qframe_tick,
    input  logic        hframe_tick,
    output logic        loop,
    output logic        disableFlag,
    output logic [3:0]  n,
    output logic        resetFlag,
    output logic [1:0]  duty,
    output logic [7:0]  sweep_cfg,
    output logic        sweep_reload,
    output logic [10:0] timer_period,
    output logic        seq_reset,
    output logic        length_active
);

    // Write handshake: wr_en is a one-cycle strobe with no ready; every strobe is
    // accepted on its clk edge and its effects are visible on the next cycle.
    logic wr_ctrl, wr_sweep, wr_tlo, wr_thi;
    logic [7:0] timer_lo;
    logic [2:0] timer_hi;

    assign wr_ctrl  = wr_en && (addr == REG_CTRL);
    assign wr_sweep = wr_en && (addr == REG_SWEEP);
    assign wr_tlo   = wr_en && (addr == REG_TLO);
    assign wr_thi   = wr_en && (addr == REG_THI);

    always_ff @(posedge clk) begin
        if (!rst) begin
            duty        <= 2'd0;
            loop        <= 1'b0;
            disableFlag <= 1'b0;
            n           <= 4'd0;
            sweep_cfg   <= 8'd0;
            timer_lo    <= 8'd0;
            timer_hi    <= 3'd0;
        end else begin
            if (wr_ctrl) begin
                duty        <= wdata[7:6];
                loop        <= wdata[5];
                disableFlag <= wdata[4];
                n           <= wdata[3:0];
            end
            if (wr_sweep) sweep_cfg <= wdata;
            if (wr_tlo)   timer_lo  <= wdata;
            if (wr_thi)   timer_hi  <= wdata[2:0];
        end
    end

    // Set wins over a same-cycle clearing tick for both pending flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resetFlag    <= 1'b0;
            sweep_reload <= 1'b0;
            seq_reset    <= 1'b0;
        end else begin
            seq_reset <= wr_thi;
            if (wr_thi)           resetFlag <= 1'b1;
            else if (qframe_tick) resetFlag <= 1'b0;
            if (wr_sweep)         sweep_reload <= 1'b1;
            else if (hframe_tick) sweep_reload <= 1'b0;
        end
    end

    assign timer_period = {timer_hi, timer_lo};

    // halt uses the registered loop bit, so a same-cycle reg0 write cannot affect it.
    length_counter u_length (
        .clk         (clk),
        .rst         (rst),
        .load        (wr_thi),
        .load_idx    (wdata[7:3]),
        .halt        (loop),
        .hframe_tick (hframe_tick),
        .ch_enable   (ch_enable),
        .active      (length_active)
    );

endmodule

// File: tb/tb_pulse_reg_writer.sv
// Directed bench for pulse_reg_writer with hand-computed expected values.
module tb_pulse_reg_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        ch_enable;
    logic        qframe_tick;
    logic        hframe_tick;
    logic        loop;
    logic        disableFlag;
    logic [3:0]  n;
    logic        resetFlag;
    logic [1:0]  duty;
    logic [7:0]  sweep_cfg;
    logic        sweep_reload;
    logic [10:0] timer_period;
    logic        seq_reset;
    logic        length_active;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_reg_writer dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .addr          (addr),
        .wdata         (wdata),
        .ch_enable     (ch_enable),
        .qframe_tick   (qframe_tick),
        .hframe_tick   (hframe_tick),
        .loop          (loop),
        .disableFlag   (disableFlag),
        .n             (n),
        .resetFlag     (resetFlag),
        .duty          (duty),
        .sweep_cfg     (sweep_cfg),
        .sweep_reload  (sweep_reload),
        .timer_period  (timer_period),
        .seq_reset     (seq_reset),
        .length_active (length_active)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        wr_en       = 1'b0;
        qframe_tick = 1'b0;
        hframe_tick = 1'b0;
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        set_wr(a, d);
        tick();
        idle();
    endtask

    task automatic hframe();
        hframe_tick = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1; ch_enable = 1'b1; addr = 2'd0; wdata = 8'd0;
        idle();
        tick();

        // Reset after random writes, with a write and ticks active during reset.
        for (int i = 0; i < 4; i++) write(2'(i), 8'($urandom_range(255)));
        rst = 1'b0;
        set_wr(2'd3, 8'h08); qframe_tick = 1'b1; hframe_tick = 1'b1;
        tick(); tick();
        idle(); rst = 1'b1;
        check("rst_loop", 16'(loop), 16'h0);
        check("rst_disable", 16'(disableFlag), 16'h0);
        check("rst_n", 16'(n), 16'h0);
        check("rst_resetFlag", 16'(resetFlag), 16'h0);
        check("rst_duty", 16'(duty), 16'h0);
        check("rst_sweep_cfg", 16'(sweep_cfg), 16'h0);
        check("rst_sweep_reload", 16'(sweep_reload), 16'h0);
        check("rst_timer", 16'(timer_period), 16'h0);
        check("rst_seq_reset", 16'(seq_reset), 16'h0);
        check("rst_active", 16'(length_active), 16'h0);

        // Envelope control write.
        write(2'd0, 8'hBF);
        check("ctrl_duty", 16'(duty), 16'h2);
        check("ctrl_loop", 16'(loop), 16'h1);
        check("ctrl_disable", 16'(disableFlag), 16'h1);
        check("ctrl_n", 16'(n), 16'hF);
        check("ctrl_resetFlag", 16'(resetFlag), 16'h0);
        check("ctrl_active", 16'(length_active), 16'h0);

        // Start flag and length load (idx 1 = 254).
        write(2'd3, 8'h08);
        check("start_resetFlag", 16'(resetFlag), 16'h1);
        check("start_seq_reset", 16'(seq_reset), 16'h1);
        check("start_active", 16'(length_active), 16'h1);
        check("start_timer", 16'(timer_period), 16'h000);
        tick();
        check("seq_reset_one_cycle", 16'(seq_reset), 16'h0);
        check("resetFlag_held", 16'(resetFlag), 16'h1);
        qframe_tick = 1'b1; tick(); idle();
        check("resetFlag_qclear", 16'(resetFlag), 16'h0);

        // Timer assembly; idx 0 loads 10.
        write(2'd2, 8'hA5);
        check("timer_lo", 16'(timer_period), 16'h0A5);
        write(2'd3, 8'h07);
        check("timer_full", 16'(timer_period), 16'h7A5);

        // Countdown with loop=0: idx 3 = length 2.
        write(2'd0, 8'h00);
        write(2'd3, 8'h18);
        hframe();
        check("cnt_after1", 16'(length_active), 16'h1);
        hframe();
        check("cnt_after2", 16'(length_active), 16'h0);
        hframe();
        check("cnt_after3", 16'(length_active), 16'h0);

        // Halted: two ticks keep length 2; a same-cycle reg0 write doesn't unhalt.
        write(2'd0, 8'h20);
        write(2'd3, 8'h18);
        hframe(); hframe();
        set_wr(2'd0, 8'h00); hframe_tick = 1'b1; tick(); idle();
        check("halt_loop_cleared", 16'(loop), 16'h0);
        hframe();
        check("halt_len_was2", 16'(length_active), 16'h1);
        hframe();
        check("halt_len_now0", 16'(length_active), 16'h0);

        // addr 3 write coincident with both ticks.
        qframe_tick = 1'b1; tick(); idle();
        check("pre_sim_resetFlag", 16'(resetFlag), 16'h0);
        set_wr(2'd3, 8'h18); qframe_tick = 1'b1; hframe_tick = 1'b1; tick(); idle();
        check("sim_resetFlag", 16'(resetFlag), 16'h1);
        hframe();
        check("sim_no_decrement", 16'(length_active), 16'h1);
        hframe();
        check("sim_len_end", 16'(length_active), 16'h0);

        // Sweep register and reload flag.
        write(2'd1, 8'h9C);
        check("sweep_cfg", 16'(sweep_cfg), 16'h9C);
        check("sweep_reload_set", 16'(sweep_reload), 16'h1);
        hframe();
        check("sweep_reload_clr", 16'(sweep_reload), 16'h0);
        set_wr(2'd1, 8'h41); hframe_tick = 1'b1; tick(); idle();
        check("sweep_reload_sim", 16'(sweep_reload), 16'h1);
        check("sweep_cfg2", 16'(sweep_cfg), 16'h41);

        // Enable gating.
        ch_enable = 1'b0;
        write(2'd3, 8'h0A);
        check("dis_no_load", 16'(length_active), 16'h0);
        check("dis_timer_upd", 16'(timer_period), 16'h2A5);
        ch_enable = 1'b1;
        write(2'd3, 8'h08);
        check("en_load", 16'(length_active), 16'h1);
        ch_enable = 1'b0; tick();
        check("drop_enable", 16'(length_active), 16'h0);
        ch_enable = 1'b1; tick(); tick();
        check("reenable_stays0", 16'(length_active), 16'h0);
        write(2'd3, 8'h08);
        check("reenable_load", 16'(length_active), 16'h1);
        ch_enable = 1'b0; set_wr(2'd3, 8'h08); tick(); idle();
        check("fall_with_write", 16'(length_active), 16'h0);
        ch_enable = 1'b1;

        // Reset mid-countdown.
        write(2'd3, 8'h08);
        check("pre_rst_active", 16'(length_active), 16'h1);
        rst = 1'b0; hframe_tick = 1'b1; tick(); idle(); rst = 1'b1;
        check("midrst_active", 16'(length_active), 16'h0);
        check("midrst_timer", 16'(timer_period), 16'h0);
        check("midrst_resetFlag", 16'(resetFlag), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_reg_writer.md
# pulse_reg_writer

CPU-facing register writer for one APU pulse channel. Decodes byte writes to the channel's four registers ($4000–$4003 offsets 0–3) and drives the envelope generator's control inputs (`loop`, `disableFlag`, `resetFlag`, `n`), along with duty, sweep and timer fields. Owns the channel's length counter, which is clocked by frame-sequencer ticks. Sits between the CPU bus decode and the pulse channel datapath (envelope, sweep, timer).

## Interface
- No parameters.
- `clk`  in  1  system clock, same domain as the envelope.
- `rst`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  write strobe, one cycle per CPU write.
- `addr`  in  2  register offset 0–3.
- `wdata`  in  8  write data.
- `ch_enable`  in  1  channel enable from the status register ($4015 bit).
- `qframe_tick`  in  1  quarter-frame pulse, one cycle.
- `hframe_tick`  in  1  half-frame pulse, one cycle.
- `loop`  out  1  reg0 bit 5; also the length-counter halt.
- `disableFlag`  out  1  reg0 bit 4 (constant volume).
- `n`  out  4  reg0 bits 3:0.
- `resetFlag`  out  1  envelope start flag.
- `duty`  out  2  reg0 bits 7:6.
- `sweep_cfg`  out  8  reg1 raw.
- `sweep_reload`  out  1  sweep reload flag.
- `timer_period`  out  11  {reg3[2:0], reg2}.
- `seq_reset`  out  1  duty-sequencer phase reset, one cycle.
- `length_active`  out  1  high when length ≠ 0.

## Operation
- Writes are registered: fields update on the `clk` edge where `wr_en` is high, and are visible the next cycle.
- **addr 0:** updates `duty`, `loop`, `disableFlag`, `n`. Does not touch `resetFlag` or length.
- **addr 1:** updates `sweep_cfg` and sets `sweep_reload`.
  - `sweep_reload` clears on the next `hframe_tick`.
- **addr 2:** updates timer low byte.
- **addr 3:** updates timer high bits and sets `resetFlag`.
  - Pulses `seq_reset` for exactly one cycle.
  - If `ch_enable`=1, loads length = LEN_TABLE[wdata[7:3]].
- **`resetFlag` (pending start):**
  - Set by an addr 3 write.
  - Cleared on the first `qframe_tick` strictly after the set cycle.
  - The envelope samples it every clk, so holding it is harmless.
- **Length counter (8-bit):**
  - On `hframe_tick`, decrements if ≠0 and `loop`=0.
  - Holds at 0; no wrap.
- **`ch_enable`=0:** length is forced to 0 each cycle and addr 3 length loads are ignored. Other fields still update.
- **Simultaneous events:**
  - addr 3 write + `qframe_tick`: `resetFlag` ends set.
  - addr 3 write + `hframe_tick`: load wins, no decrement.
  - addr 1 write + `hframe_tick`: `sweep_reload` ends set.
  - `ch_enable` falling + addr 3 write: length = 0.
- **Halt timing:** the `loop` value used for the halt is the registered value before any same-cycle addr 0 write.

## Timing
- **Reset (`rst`=0 at clk edge):** all registers 0.
  - `loop`=0, `disableFlag`=0, `n`=0, `resetFlag`=0, `duty`=0.
  - `sweep_cfg`=0, `sweep_reload`=0, `timer_period`=0, `seq_reset`=0.
  - Length = 0, so `length_active`=0.
  - Reset overrides any same-cycle write or tick. Reset mid-countdown zeroes the length immediately.
- **Latency:** one cycle from the `wr_en` edge to all affected outputs.
- `length_active` is combinational from the length register, so it has no extra latency.
- There is no backpressure: every `wr_en` is accepted. Back-to-back writes on consecutive cycles are legal.
- Tick inputs are assumed single-cycle. A tick held high for k cycles acts as k ticks.

## Structure
- **Package `apu_pkg`:**
  - `LEN_TABLE[32]` (8-bit entries, NES standard: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30).
  - Register offset constants `REG_CTRL`=0, `REG_SWEEP`=1, `REG_TLO`=2, `REG_THI`=3.
- **Sub-module `length_counter`:**
  - Inputs: `clk`, `rst`, `load`, `load_idx[4:0]`, `halt`, `hframe_tick`, `ch_enable`.
  - Output: `active`.
  - Reused by the triangle and noise channels.

## Test plan
- **Reset:** `rst`=0 for 2 cycles after random writes → every output 0 the cycle after.
- **Envelope control write:** write addr 0 = 0xBF → next cycle `duty`=2, `loop`=1, `disableFlag`=1, `n`=15. `resetFlag` stays 0.
- **Start flag and length load:** `ch_enable`=1, write addr 3 = 0x08 (idx 1) →
  - Next cycle: `resetFlag`=1, `seq_reset`=1 for one cycle, length=254, `timer_period`[10:8]=0.
  - First `qframe_tick` → `resetFlag`=0.
- **Length countdown and halt:** load idx 3 (length 2) with `loop`=0, then 2 `hframe_tick`s → `length_active` falls after the second tick. A third tick → stays 0.
  - Repeat with `loop`=1 → length stays 2.
- **Simultaneous events:** addr 3 write in the same cycle as `qframe_tick` and `hframe_tick` → `resetFlag`=1 and length = table value, with no decrement.
- **Enable gating:** `ch_enable`=0 then write addr 3 → `length_active` stays 0.
  - Drop `ch_enable` mid-count → length 0 next cycle.
  - Reassert `ch_enable` → stays 0 until the next addr 3 write.
